// File: rtl/mem_wb_writeback.sv
// Memory/writeback boundary: captures the memory-stage result, formats load data,
// issues exactly one register-file write per instruction and counts retirements.
module mem_wb_writeback #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mem_done,
  input  logic [XLEN-1:0] alu_data,
  input  logic [XLEN-1:0] load_data,
  input  logic [2:0]      mem_addr_lo,
  input  logic [1:0]      mem_size,
  input  logic            mem_unsigned,
  input  logic            is_load,
  input  logic            reg_write,
  input  logic [4:0]      rd,
  input  logic            wb_stall,
  output logic            mem_wb_valid,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            misaligned_load,
  output logic [63:0]     instret
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WRITE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] alu_data_q;
  logic [XLEN-1:0] load_fmt_q;
  logic            is_load_q;
  logic            reg_write_q;
  logic [4:0]      rd_q;
  logic            misaligned_q;

  logic [XLEN-1:0] load_shifted;
  logic [XLEN-1:0] load_fmt;
  logic            misaligned;

  assign load_shifted = load_data >> {mem_addr_lo, 3'b000};

  always_comb begin
    load_fmt = load_shifted;
    case (mem_size)
      2'd0: load_fmt = mem_unsigned ? {{(XLEN-8){1'b0}}, load_shifted[7:0]}
                                    : {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
      2'd1: load_fmt = mem_unsigned ? {{(XLEN-16){1'b0}}, load_shifted[15:0]}
                                    : {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      2'd2: load_fmt = mem_unsigned ? {{(XLEN-32){1'b0}}, load_shifted[31:0]}
                                    : {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
      default: load_fmt = load_shifted;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (mem_size)
      2'd1:    misaligned = mem_addr_lo[0];
      2'd2:    misaligned = |mem_addr_lo[1:0];
      2'd3:    misaligned = |mem_addr_lo;
      default: misaligned = 1'b0;
    endcase
    misaligned = misaligned & is_load;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      mem_wb_valid <= 1'b0;
      alu_data_q   <= '0;
      load_fmt_q   <= '0;
      is_load_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
      instret      <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (mem_done) begin
            alu_data_q   <= alu_data;
            load_fmt_q   <= load_fmt;
            is_load_q    <= is_load;
            reg_write_q  <= reg_write;
            rd_q         <= rd;
            misaligned_q <= misaligned;
            mem_wb_valid <= 1'b1;
            state        <= WRITE;
          end
        end
        WRITE: begin
          if (!wb_stall) begin
            if (!misaligned_q) instret <= instret + 64'd1;
            // A still-asserted mem_done belongs to this instruction; wait it out in DRAIN.
            if (mem_done) begin
              state <= DRAIN;
            end else begin
              state        <= EMPTY;
              mem_wb_valid <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (!mem_done) begin
            state        <= EMPTY;
            mem_wb_valid <= 1'b0;
          end
        end
        default: begin
          state        <= EMPTY;
          mem_wb_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rf_we = (state == WRITE) & reg_write_q & (rd_q != 5'd0) & ~misaligned_q & ~wb_stall;
  assign rf_waddr = rd_q;
  assign rf_wdata = is_load_q ? load_fmt_q : alu_data_q;
  assign misaligned_load = misaligned_q & (state != EMPTY);

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomized bench for mem_wb_writeback: per-instruction reference model of the
// writeback value, write enable, misalignment and retire count.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_done;
  logic [63:0] alu_data;
  logic [63:0] load_data;
  logic [2:0]  mem_addr_lo;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        is_load;
  logic        reg_write;
  logic [4:0]  rd;
  logic        wb_stall;
  logic        mem_wb_valid;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        misaligned_load;
  logic [63:0] instret;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_instret;

  mem_wb_writeback #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .mem_done(mem_done), .alu_data(alu_data),
    .load_data(load_data), .mem_addr_lo(mem_addr_lo), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .is_load(is_load), .reg_write(reg_write), .rd(rd),
    .wb_stall(wb_stall), .mem_wb_valid(mem_wb_valid), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .misaligned_load(misaligned_load),
    .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference load formatting: arithmetic on the access width, not bit slicing per size.
  function automatic logic [63:0] fmt_load(logic [63:0] ld, int lo, int sz, bit un);
    logic [63:0] sh;
    logic [63:0] mask;
    logic [63:0] v;
    int          nb;
    sh = ld >> (lo * 8);
    nb = 8 << sz;
    if (nb == 64) return sh;
    mask = (64'd1 << nb) - 64'd1;
    v = sh & mask;
    if (!un && v[nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic scramble();
    alu_data     = {$urandom, $urandom};
    load_data    = {$urandom, $urandom};
    mem_addr_lo  = 3'($urandom);
    mem_size     = 2'($urandom);
    mem_unsigned = 1'($urandom);
    is_load      = 1'($urandom);
    reg_write    = 1'($urandom);
    rd           = 5'($urandom);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 64'(mem_wb_valid), 64'd0);
    check({tag, "_we"}, 64'(rf_we), 64'd0);
    check({tag, "_mis"}, 64'(misaligned_load), 64'd0);
    check({tag, "_instret"}, instret, exp_instret);
  endtask

  // One instruction: capture, `stalls` stalled WRITE cycles, retire, then `drain`
  // cycles of held mem_done (0 = mem_done drops in the retiring cycle).
  task automatic run_txn(input logic [63:0] a, input logic [63:0] ld, input int lo,
                         input int sz, input bit un, input bit il, input bit rw,
                         input int r, input int stalls, input int drain);
    bit          mis;
    bit          we_base;
    logic [63:0] exp_wd;
    mis     = il && ((lo % (1 << sz)) != 0);
    we_base = rw && (r != 0) && !mis;
    exp_wd  = il ? fmt_load(ld, lo, sz, un) : a;

    @(negedge clk);
    #1;
    check_idle("empty");
    alu_data = a; load_data = ld; mem_addr_lo = 3'(lo); mem_size = 2'(sz);
    mem_unsigned = un; is_load = il; reg_write = rw; rd = 5'(r);
    wb_stall = 1'($urandom);
    mem_done = 1'b1;

    for (int i = 0; i <= stalls; i++) begin
      @(negedge clk);
      scramble();
      wb_stall = (i < stalls);
      mem_done = (i < stalls) ? 1'($urandom) : (drain > 0);
      #1;
      check("w_valid", 64'(mem_wb_valid), 64'd1);
      check("w_we", 64'(rf_we), 64'(we_base && (i == stalls)));
      check("w_mis", 64'(misaligned_load), 64'(mis));
      check("w_waddr", 64'(rf_waddr), 64'(r));
      check("w_wdata", rf_wdata, exp_wd);
      check("w_instret", instret, exp_instret);
    end
    if (!mis) exp_instret = exp_instret + 64'd1;

    for (int j = 0; j < drain; j++) begin
      @(negedge clk);
      scramble();
      wb_stall = 1'($urandom);
      mem_done = (j < drain - 1);
      #1;
      check("d_valid", 64'(mem_wb_valid), 64'd1);
      check("d_we", 64'(rf_we), 64'd0);
      check("d_mis", 64'(misaligned_load), 64'(mis));
      check("d_instret", instret, exp_instret);
    end
  endtask

  initial begin
    reset = 1'b1; mem_done = 1'b0; wb_stall = 1'b0;
    alu_data = '0; load_data = '0; mem_addr_lo = '0; mem_size = '0;
    mem_unsigned = 1'b0; is_load = 1'b0; reg_write = 1'b0; rd = '0;
    exp_instret = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle("reset");
    check("reset_waddr", 64'(rf_waddr), 64'd0);
    check("reset_wdata", rf_wdata, 64'd0);

    // ALU op, LB/LBU, LW/LWU, misaligned LH, stall, rd=0 stall
    run_txn(64'h1234, 64'h0, 0, 0, 0, 0, 1, 5, 0, 2);
    run_txn(64'h0, 64'h0000_0000_8000_0000, 3, 0, 0, 1, 1, 7, 0, 0);
    run_txn(64'h0, 64'h0000_0000_8000_0000, 3, 0, 1, 1, 1, 7, 0, 1);
    run_txn(64'h0, 64'hDEAD_BEEF_0000_0001, 4, 2, 0, 1, 1, 9, 0, 0);
    run_txn(64'h0, 64'hDEAD_BEEF_0000_0001, 4, 2, 1, 1, 1, 9, 1, 0);
    run_txn(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 1, 1, 3, 0, 1);
    run_txn(64'hCAFE, 64'h0, 0, 0, 0, 0, 1, 12, 3, 1);
    run_txn(64'hBEEF, 64'h0, 0, 0, 0, 0, 1, 0, 3, 0);
    run_txn(64'h0, 64'h8877_6655_4433_2211, 0, 3, 1, 1, 1, 31, 0, 0);

    for (int k = 0; k < 150; k++)
      run_txn({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 7)),
              int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 2)));

    // Reset in a stalled WRITE drops the pending write.
    @(negedge clk);
    alu_data = 64'h55; is_load = 1'b0; reg_write = 1'b1; rd = 5'd4; mem_done = 1'b1;
    @(negedge clk);
    wb_stall = 1'b1;
    #1;
    check("rst_pre_valid", 64'(mem_wb_valid), 64'd1);
    check("rst_pre_we", 64'(rf_we), 64'd0);
    reset = 1'b1; mem_done = 1'b0;
    @(negedge clk);
    reset = 1'b0; wb_stall = 1'b0;
    exp_instret = '0;
    #1;
    check_idle("rst_mid");
    check("rst_mid_wdata", rf_wdata, 64'd0);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    run_txn(64'h77, 64'h0, 0, 0, 0, 0, 1, 2, 0, 0);
    @(negedge clk);
    #1;
    check_idle("wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

Memory/writeback boundary stage of the pipelined core. It latches the result of the memory stage when that stage raises `mem_done`, and answers with the `mem_wb_valid` handshake. It formats load data (lane select plus sign/zero extension) and drives the integer register-file write port exactly once per instruction. It also maintains the retired-instruction counter.

## Interface
Parameters:
- `XLEN`, 64, datapath width; the only supported value is 64.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `mem_done`  in  1  memory stage result ready (level); held until `mem_wb_valid` is seen.
- `alu_data`  in  64  ALU result (non-load writeback value).
- `load_data`  in  64  naturally aligned doubleword containing the load address.
- `mem_addr_lo`  in  3  `alu_data[2:0]` of the access.
- `mem_size`  in  2  0=byte, 1=half, 2=word, 3=double.
- `mem_unsigned`  in  1  1 = zero-extend (LBU/LHU/LWU).
- `is_load`  in  1  instruction is a load.
- `reg_write`  in  1  instruction writes rd.
- `rd`  in  5  destination register.
- `wb_stall`  in  1  register-file port unavailable this cycle.
- `mem_wb_valid`  out  1  pipeline-valid handshake back to the memory stage.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  write address.
- `rf_wdata`  out  64  write data.
- `misaligned_load`  out  1  sticky flag for the held instruction: load was misaligned, write suppressed.
- `instret`  out  64  retired-instruction count.

## Operation
- The FSM has three states: EMPTY, WRITE, DRAIN.
- **EMPTY:**
  - When `mem_done`=1, capture all data and control inputs into holding registers, set `mem_wb_valid`=1, and go to WRITE.
  - Inputs are ignored while `mem_done`=0.
- **WRITE:**
  - `rf_we` = `reg_write_q` & (`rd_q`≠0) & !`misaligned_q` & !`wb_stall`.
  - `rf_we`, `rf_waddr`, and `rf_wdata` are combinational from the holding registers only.
  - If `wb_stall`=1, remain in WRITE.
  - Otherwise, retire:
    - Increment `instret` by 1, unless `misaligned_q`=1.
    - Go to EMPTY if `mem_done`=0, else go to DRAIN.
- **DRAIN:**
  - `mem_wb_valid` stays 1 and `rf_we`=0.
  - When `mem_done`=0 is sampled, go to EMPTY.
- `mem_wb_valid` = (state ≠ EMPTY), registered.
- **Load formatting**, computed at capture and stored:
  - Shift `load_data` right by `mem_addr_lo`×8.
  - Take the low 8/16/32/64 bits according to `mem_size`.
  - Sign-extend, or zero-extend if `mem_unsigned`. `mem_unsigned` is ignored for size 3.
- **Misaligned load:**
  - A load is misaligned if size 1 with `addr[0]`≠0, size 2 with `addr[1:0]`≠0, or size 3 with `addr[2:0]`≠0.
  - On a misaligned load: `misaligned_q`=1, the write is suppressed, and the instruction is not counted.
- `rf_wdata` = formatted load data if `is_load_q`, else `alu_data_q`.
- `misaligned_load` = `misaligned_q` while state ≠ EMPTY, else 0.
- `instret` is a 64-bit counter that wraps from all-ones to 0.

## Timing
- **Reset (any state, mid-operation included):**
  - State → EMPTY; holding registers → 0; `instret` → 0.
  - The pending write is dropped.
  - All outputs read 0 in the cycle after reset is sampled.
- **Latency:** `mem_done` high at edge N → `mem_wb_valid`=1 and `rf_we` possible in cycle N+1. The minimum occupancy is 2 cycles per instruction.
- **Exactly one write per capture:**
  - `rf_we` is never asserted in EMPTY or DRAIN.
  - Held `mem_done` never causes a second capture, because DRAIN waits for it to drop.
- **`wb_stall`:**
  - Extends WRITE indefinitely.
  - `mem_wb_valid` and all held values stay stable throughout.
- **`mem_done` falling:**
  - In WRITE with `wb_stall`=1: no effect; the FSM stays in WRITE.
  - Same cycle as a non-stalled WRITE: WRITE→EMPTY directly.
- **Back-to-back:** `mem_done` is sampled only in EMPTY. A re-assertion in the same cycle as a DRAIN→EMPTY transition is captured on the following edge.
- **rd=0:** the FSM still transitions and counts; `rf_we` stays 0.

## Test plan
- **ALU op.** `reg_write`=1, rd=5, `alu_data`=0x1234, `mem_done` pulsed then held 2 cycles → `mem_wb_valid` rises next cycle; one `rf_we` pulse with waddr 5, wdata 0x1234; `instret`=1; valid drops after `mem_done` falls.
- **LB sign extend.** `load_data`=0x0000_0000_8000_0000, `mem_addr_lo`=3, size 0, signed → wdata 0xFFFF_FFFF_FFFF_FF80. The same case with LBU → 0x80.
- **LW at offset 4.** `load_data`=0xDEAD_BEEF_0000_0001, `mem_addr_lo`=4, size 2, signed → wdata 0xFFFF_FFFF_DEAD_BEEF. LWU → 0x0000_0000_DEAD_BEEF.
- **Misaligned LH.** `mem_addr_lo`=1, size 1 → `misaligned_load`=1; `rf_we` never asserts; `instret` unchanged.
- **Stall.** `wb_stall`=1 for 3 cycles in WRITE → `rf_we`=0, outputs stable; one `rf_we` pulse on the first unstalled cycle. rd=0 variant → no `rf_we`, `instret`+1.
- **Reset.** Assert `reset` during WRITE with `wb_stall`=1 → next cycle valid=0, `instret`=0, `rf_we`=0. Preload `instret`=2^64−1 via a long run (or force) → one retire wraps it to 0.
